// File: rtl/mem_block_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_block_responder
// Description : Block-wide main-memory responder for the write-back cache.
//               Serves refills and write-backs after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADR_WIDTH    = 16,
  parameter int OFFSET_WIDTH = 2,
  parameter int STORE_WIDTH  = 10,
  parameter int LATENCY      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_rd,
  input  logic                      m_wr,
  input  logic [ADR_WIDTH-1:0]      m_address,
  input  logic [4*DATA_WIDTH-1:0]   m_blockin,
  output logic [4*DATA_WIDTH-1:0]   m_blockout,
  output logic                      m_ready
);

  localparam int         c_blk_w    = 4 * DATA_WIDTH;
  localparam int         c_depth    = 1 << STORE_WIDTH;
  localparam logic [7:0] c_cnt_load = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [7:0]               r_count;
  logic [7:0]               w_count_next;
  logic [STORE_WIDTH-1:0]   r_index;
  logic [STORE_WIDTH-1:0]   w_index;
  logic [c_blk_w-1:0]       r_block;
  logic [c_blk_w-1:0]       w_block;
  logic                     r_op_wr;
  logic                     w_op_wr;
  logic                     r_ready;
  logic [c_blk_w-1:0]       r_blockout;
  logic                     w_enter_resp;
  logic                     w_req;
  logic [STORE_WIDTH-1:0]   w_in_index;
  logic                     w_unused;

  logic [c_blk_w-1:0]       r_mem [0:c_depth-1];

  // Upper block-address bits are dropped on purpose, so distant blocks alias.
  assign w_in_index = m_address[OFFSET_WIDTH+STORE_WIDTH-1:OFFSET_WIDTH];
  assign w_req      = m_rd | m_wr;
  assign w_unused   = &{1'b0, m_address};

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_index      = r_index;
    w_block      = r_block;
    w_op_wr      = r_op_wr;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_index      = w_in_index;
          w_block      = m_blockin;
          w_op_wr      = m_wr;
          w_count_next = c_cnt_load;
          w_state_next = (c_cnt_load == 8'd0) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Leave on the cycle the count reaches zero.
        w_count_next = r_count - 8'd1;
        if (r_count <= 8'd1) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_next == ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_count    <= 8'd0;
      r_index    <= '0;
      r_block    <= '0;
      r_op_wr    <= 1'b0;
      r_ready    <= 1'b0;
      r_blockout <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_index <= w_index;
      r_block <= w_block;
      r_op_wr <= w_op_wr;
      r_ready <= w_enter_resp;
      if (w_enter_resp && !w_op_wr) begin
        r_blockout <= r_mem[w_index];
      end
    end
  end

  // Storage has no reset; a write in flight during reset never lands.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_wr && rst) begin
      r_mem[w_index] <= w_block;
    end
  end

  assign m_ready    = r_ready;
  assign m_blockout = r_blockout;

endmodule
`default_nettype wire

// File: tb/tb_mem_block_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_responder
// Description : Scoreboard bench for mem_block_responder at latencies 4, 1, 255.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd     [3];
  logic        wr     [3];
  logic [15:0] addr   [3];
  logic [63:0] blkin  [3];
  logic [63:0] blkout [3];
  logic        ready  [3];

  always #5 clk = ~clk;

  mem_block_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .m_rd(rd[0]), .m_wr(wr[0]), .m_address(addr[0]),
    .m_blockin(blkin[0]), .m_blockout(blkout[0]), .m_ready(ready[0])
  );
  mem_block_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .m_rd(rd[1]), .m_wr(wr[1]), .m_address(addr[1]),
    .m_blockin(blkin[1]), .m_blockout(blkout[1]), .m_ready(ready[1])
  );
  mem_block_responder #(.LATENCY(255)) u_dut_l255 (
    .clk(clk), .rst(rst), .m_rd(rd[2]), .m_wr(wr[2]), .m_address(addr[2]),
    .m_blockin(blkin[2]), .m_blockout(blkout[2]), .m_ready(ready[2])
  );

  typedef struct {
    int          dut;
    int          at_cyc;
    logic [63:0] data;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 255;
    endcase
  endfunction

  // A response is seen on the falling edge after the rising edge that raised m_ready.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ready[d] === 1'b1) begin
        if (sb.size() == 0) begin
          check_val("spurious_ready", 64'(d), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check_val("ready_dut", 64'(d), 64'(e.dut));
          check_val("ready_cycle", 64'(cyc), 64'(e.at_cyc));
          if (e.chk) check_val("blockout", blkout[d], e.data);
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    bit ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("ready_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic req(input int d, input bit r, input bit w, input logic [15:0] a,
                     input logic [63:0] b, input logic [63:0] expd, input bit chk);
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; blkin[d] = b;
    sb.push_back('{dut: d, at_cyc: cyc + lat_of(d), data: expd, chk: chk});
    wait_ready(d);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  // A read held through its response is re-accepted one idle cycle later.
  task automatic held_reads(input int d, input logic [15:0] a, input logic [63:0] expd);
    @(negedge clk);
    rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = a;
    sb.push_back('{dut: d, at_cyc: cyc + lat_of(d), data: expd, chk: 1'b1});
    sb.push_back('{dut: d, at_cyc: cyc + 2 * lat_of(d) + 1, data: expd, chk: 1'b1});
    wait_ready(d);
    wait_ready(d);
    rd[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; blkin[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check_val("idle_ready", 64'(ready[0]), 64'd0);
      check_val("idle_blockout", blkout[0], 64'h0);
    end

    req(0, 1'b0, 1'b1, 16'h0124, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0);
    req(0, 1'b1, 1'b0, 16'h0127, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b1);

    req(0, 1'b0, 1'b1, 16'h0010, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b0);
    req(0, 1'b1, 1'b0, 16'h1010, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);

    // Simultaneous read and write: write wins, read data stays put.
    req(0, 1'b1, 1'b1, 16'h0200, 64'hCAFE_F00D_1234_5678, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    req(0, 1'b1, 1'b0, 16'h0200, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b1);

    req(0, 1'b0, 1'b1, 16'h0300, 64'h1111_1111_1111_1111, 64'h0, 1'b0);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 16'h0300; blkin[0] = 64'h2222_2222_2222_2222;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 64'(ready[0]), 64'd0);
    check_val("rst_blockout", blkout[0], 64'h0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    req(0, 1'b1, 1'b0, 16'h0300, 64'h0, 64'h1111_1111_1111_1111, 1'b1);

    held_reads(0, 16'h0124, 64'hDEAD_BEEF_0123_4567);

    for (int d = 1; d < 3; d++) begin
      req(d, 1'b0, 1'b1, 16'h0044, 64'h5555_0000_0000_0000 + 64'(d), 64'h0, 1'b0);
      req(d, 1'b1, 1'b0, 16'h0044, 64'h0, 64'h5555_0000_0000_0000 + 64'(d), 1'b1);
      held_reads(d, 16'h0044, 64'h5555_0000_0000_0000 + 64'(d));
    end

    repeat (5) @(negedge clk);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
